// File: rtl/jtopl_pg_state.sv
// Phase-generator state for the time-multiplexed operator slots: slot counter,
// circular phase store, keyon-edge detection and the registers around the generator.
module jtopl_pg_state #(
   parameter int SLOTS = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        keyon,
   input  logic [16:0] phinc_out,
   input  logic [18:0] phase_out,
   input  logic [9:0]  phase_op,
   output logic [16:0] phinc_in,
   output logic [18:0] phase_in,
   output logic        pg_rst,
   output logic [9:0]  op_phase,
   output logic [4:0]  slot,
   output logic        zero
);

   localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

   // Head of each shift register belongs to the slot being served; the tail
   // receives the fresh value so it returns to the head after SLOTS steps.
   logic [18:0]      phase_store [SLOTS];
   logic [SLOTS-1:0] keyon_hist;

   assign phase_in = phase_store[0];
   assign zero     = (slot == 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         slot       <= '0;
         phinc_in   <= '0;
         pg_rst     <= 1'b0;
         op_phase   <= '0;
         keyon_hist <= '0;
         for (int i = 0; i < SLOTS; i++) phase_store[i] <= '0;
      end else if (cen) begin
         slot       <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
         phinc_in   <= phinc_out;
         op_phase   <= phase_op;
         pg_rst     <= keyon & ~keyon_hist[0];
         keyon_hist <= {keyon, keyon_hist[SLOTS-1:1]};
         for (int i = 0; i < SLOTS - 1; i++) phase_store[i] <= phase_store[i+1];
         phase_store[SLOTS-1] <= phase_out;
      end
   end

endmodule
